// File: rtl/carus_sram_streamer.sv
// carus_sram_streamer: moves a block of 32-bit words between a valid/ready
// stream and a single-port SRAM bank. Write mode streams in_* beats into the
// SRAM; read mode fetches words into a 2-entry FIFO that feeds out_*.
//
// Handshakes: a beat transfers on a rising edge where valid and ready are both
// high; valid never depends on ready, and ready may depend on valid only on the
// consumer side (req_o follows in_valid_i combinationally in write mode).
module carus_sram_streamer #(
  parameter int unsigned NUM_WORDS = 1024,
  localparam int unsigned AddrWidth = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
  localparam int unsigned LenWidth = AddrWidth + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 write_mode_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic [LenWidth-1:0]  len_i,
  output logic                 busy_o,
  output logic                 done_o,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [31:0]          in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [31:0]          out_data_o,
  output logic                 req_o,
  output logic                 we_o,
  output logic [AddrWidth-1:0] addr_o,
  output logic [31:0]          wdata_o,
  output logic [3:0]           be_o,
  input  logic [31:0]          rdata_i,
  output logic [1:0]           dbg_state_o
);

  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NUM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e               state_q, state_d;
  logic                 mode_q, mode_d;
  logic [LenWidth-1:0]  len_q, len_d;
  logic [LenWidth-1:0]  cnt_q, cnt_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic                 inflight_q, inflight_d;
  logic [31:0]          fifo_mem_q [2];
  logic [31:0]          fifo_mem_d [2];
  logic                 fifo_rd_q, fifo_rd_d;
  logic                 fifo_wr_q, fifo_wr_d;
  logic [1:0]           fifo_cnt_q, fifo_cnt_d;

  logic                 issue;
  logic                 pop;
  logic [2:0]           occ;
  logic [LenWidth-1:0]  cnt_inc;
  logic [AddrWidth-1:0] addr_nxt;

  assign dbg_state_o = state_q;

  // Next-state, FIFO bookkeeping and all outputs; outputs are forced to rest while rst_i is high.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    inflight_d  = 1'b0;
    fifo_mem_d  = fifo_mem_q;
    fifo_rd_d   = fifo_rd_q;
    fifo_wr_d   = fifo_wr_q;
    fifo_cnt_d  = fifo_cnt_q;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    out_data_o  = '0;
    req_o       = 1'b0;
    we_o        = 1'b0;
    addr_o      = '0;
    wdata_o     = '0;
    be_o        = '0;
    issue       = 1'b0;
    pop         = 1'b0;
    occ         = '0;
    cnt_inc     = cnt_q + LenWidth'(1);
    // Explicit wrap so non-power-of-2 banks never address past the last word.
    addr_nxt    = (addr_q == LastAddr) ? '0 : addr_q + AddrWidth'(1);

    if (!rst_i) begin
      busy_o      = (state_q != IDLE);
      done_o      = (state_q == DONE);
      addr_o      = addr_q;
      out_valid_o = (fifo_cnt_q != 2'd0);
      out_data_o  = out_valid_o ? fifo_mem_q[fifo_rd_q] : '0;
      pop         = out_valid_o & out_ready_i;
      // Slots already committed: stored words plus the read whose data lands next cycle.
      occ         = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};

      case (state_q)
        IDLE: begin
          if (start_i) begin
            mode_d  = write_mode_i;
            addr_d  = base_addr_i;
            len_d   = len_i;
            cnt_d   = '0;
            state_d = (len_i != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          if (mode_q) begin
            in_ready_o = (cnt_q < len_q);
            issue      = in_valid_i & in_ready_o;
          end else begin
            issue = (cnt_q < len_q) && (occ < 3'd2);
          end
          if (issue) begin
            req_o   = 1'b1;
            we_o    = mode_q;
            be_o    = 4'hF;
            wdata_o = mode_q ? in_data_i : '0;
            cnt_d   = cnt_inc;
            addr_d  = addr_nxt;
            if (cnt_inc == len_q) begin
              state_d = mode_q ? DONE : DRAIN;
            end
          end
        end
        DRAIN: begin
          if ((fifo_cnt_q == 2'd0) && !inflight_q) begin
            state_d = DONE;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      inflight_d = issue & ~mode_q;
      if (inflight_q) begin
        fifo_mem_d[fifo_wr_q] = rdata_i;
        fifo_wr_d             = ~fifo_wr_q;
      end
      if (pop) begin
        fifo_rd_d = ~fifo_rd_q;
      end
      fifo_cnt_d = fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

  // State registers; reset also drops any read still in flight so its data is discarded.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      mode_q        <= 1'b0;
      len_q         <= '0;
      cnt_q         <= '0;
      addr_q        <= '0;
      inflight_q    <= 1'b0;
      fifo_mem_q[0] <= '0;
      fifo_mem_q[1] <= '0;
      fifo_rd_q     <= 1'b0;
      fifo_wr_q     <= 1'b0;
      fifo_cnt_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
      fifo_mem_q <= fifo_mem_d;
      fifo_rd_q  <= fifo_rd_d;
      fifo_wr_q  <= fifo_wr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

endmodule

// File: tb/tb_carus_sram_streamer.sv
// Bench for carus_sram_streamer: SRAM model, stream drivers, transaction-level
// reference model with expected queues, per-cycle compare, final report.
module tb_carus_sram_streamer;

  localparam int N  = 1024;
  localparam int AW = 10;
  localparam int LW = 11;

  logic          clk = 1'b0;
  logic          rst_i, start_i, write_mode_i;
  logic [AW-1:0] base_addr_i;
  logic [LW-1:0] len_i;
  logic          busy_o, done_o;
  logic          in_valid_i, in_ready_o;
  logic [31:0]   in_data_i;
  logic          out_valid_o, out_ready_i;
  logic [31:0]   out_data_o;
  logic          req_o, we_o;
  logic [AW-1:0] addr_o;
  logic [31:0]   wdata_o;
  logic [3:0]    be_o;
  logic [31:0]   rdata_i;
  logic [1:0]    dbg_state_o;

  carus_sram_streamer #(.NUM_WORDS(N)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .write_mode_i(write_mode_i),
    .base_addr_i(base_addr_i), .len_i(len_i), .busy_o(busy_o), .done_o(done_o),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .req_o(req_o), .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o), .be_o(be_o),
    .rdata_i(rdata_i), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

  // ---------------- scoreboard / model state ----------------
  int n_total = 0;
  int n_pass  = 0;

  logic [31:0]      sram    [N];
  logic [31:0]      ref_mem [N];
  logic [31:0]      wr_src_q[$];
  logic [AW+31:0]   exp_wr_q[$];
  logic [AW-1:0]    exp_rd_addr_q[$];
  logic [31:0]      exp_q[$];

  bit               m_active, m_mode, post_rst, rd_pend;
  int               m_wr_left, m_outstanding;
  logic [AW-1:0]    rd_pend_addr;
  int               vmode, rmode;

  int               wr_log_cyc[$];
  logic [AW-1:0]    wr_log_addr[$];
  logic [31:0]      wr_log_data[$];
  logic [31:0]      pop_log_data[$];
  int               pop_log_cyc[$];
  int               busy_cnt, req_cnt, done_cyc, start_cyc;
  bit               done_seen;

  bit               was_active, pop_c, issue_rd, popped;
  int               work;
  logic [AW+31:0]   e;
  logic [AW-1:0]    a;
  logic [31:0]      d;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic zero_checks(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_req"}, req_o, 0);
    chk({tag, "_we"}, we_o, 0);
    chk({tag, "_in_ready"}, in_ready_o, 0);
    chk({tag, "_out_valid"}, out_valid_o, 0);
    chk({tag, "_addr"}, addr_o, 0);
    chk({tag, "_wdata"}, wdata_o, 0);
    chk({tag, "_be"}, be_o, 0);
    chk({tag, "_out_data"}, out_data_o, 0);
  endtask

  // ---------------- input drivers and SRAM read port ----------------
  always @(posedge clk) begin
    #1;
    in_valid_i  = (wr_src_q.size() > 0) && ((vmode == 0) || ($urandom_range(0, 1) == 1));
    in_data_i   = in_valid_i ? wr_src_q[0] : $urandom;
    case (rmode)
      0: out_ready_i = 1'b1;
      1: out_ready_i = ~out_ready_i;
      2: out_ready_i = 1'($urandom_range(0, 1));
      default: out_ready_i = 1'b0;
    endcase
    rdata_i = rd_pend ? sram[rd_pend_addr] : $urandom;
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    rd_pend      = req_o && !we_o;
    rd_pend_addr = addr_o;
    if (req_o && we_o) sram[addr_o] = wdata_o;

    if (rst_i) begin
      zero_checks("rst");
      m_active = 0; m_wr_left = 0; m_outstanding = 0;
      exp_wr_q.delete(); exp_rd_addr_q.delete(); exp_q.delete(); wr_src_q.delete();
      post_rst = 1;
    end else begin
      was_active = m_active;
      pop_c      = out_valid_o && out_ready_i;
      issue_rd   = 0;
      popped     = 0;
      if (post_rst) begin
        zero_checks("post_rst");
        post_rst = 0;
      end
      if (busy_o) busy_cnt++;
      if (req_o) req_cnt++;

      chk("busy", busy_o, m_active);
      chk("in_ready", in_ready_o, m_active && m_mode && (m_wr_left > 0));
      if (m_active && m_mode && (m_wr_left > 0) && in_valid_i) chk("wr_tput", req_o, 1);

      if (!req_o) begin
        chk("rest_we", we_o, 0);
        chk("rest_be", be_o, 0);
        chk("rest_wdata", wdata_o, 0);
      end else if (!m_active) begin
        chk("req_outside_xfer", req_o, 0);
      end else begin
        chk("req_be", be_o, 4'hF);
        chk("req_we", we_o, m_mode);
        if (m_mode) begin
          chk("wr_handshake", in_valid_i && in_ready_o, 1);
          if (exp_wr_q.size() == 0) chk("wr_extra", req_o, 0);
          else begin
            e = exp_wr_q.pop_front();
            chk("wr_addr", addr_o, e[AW+31:32]);
            chk("wr_data", wdata_o, e[31:0]);
            wr_log_cyc.push_back(cyc); wr_log_addr.push_back(addr_o); wr_log_data.push_back(wdata_o);
            m_wr_left--;
          end
        end else begin
          chk("rd_credit", (m_outstanding - int'(pop_c)) < 2, 1);
          if (exp_rd_addr_q.size() == 0) chk("rd_extra", req_o, 0);
          else chk("rd_addr", addr_o, exp_rd_addr_q.pop_front());
          issue_rd = 1;
        end
      end
      if (in_valid_i && in_ready_o && (wr_src_q.size() > 0)) void'(wr_src_q.pop_front());

      if (out_valid_o) begin
        if (m_mode || !m_active || (exp_q.size() == 0)) chk("out_unexpected", out_valid_o, 0);
        else begin
          chk("out_data", out_data_o, exp_q[0]);
          if (pop_c) begin
            void'(exp_q.pop_front());
            pop_log_data.push_back(out_data_o); pop_log_cyc.push_back(cyc);
            popped = 1;
          end
        end
      end
      m_outstanding = m_outstanding + int'(issue_rd) - int'(popped);

      if (done_o) begin
        work = exp_wr_q.size() + exp_rd_addr_q.size() + exp_q.size() + m_outstanding + m_wr_left;
        chk("done_when_complete", m_active && (work == 0), 1);
        done_seen = 1; done_cyc = cyc; m_active = 0;
      end

      if (start_i && !was_active) begin
        m_active = 1; m_mode = write_mode_i; start_cyc = cyc;
        m_wr_left = write_mode_i ? int'(len_i) : 0;
        for (int i = 0; i < int'(len_i); i++) begin
          a = AW'((int'(base_addr_i) + i) % N);
          if (write_mode_i) begin
            d = (i < wr_src_q.size()) ? wr_src_q[i] : 32'hDEAD_BEEF;
            exp_wr_q.push_back({a, d});
            ref_mem[a] = d;
          end else begin
            exp_rd_addr_q.push_back(a);
            exp_q.push_back(ref_mem[a]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(posedge clk); #1;
    rst_i = 1; start_i = 0;
    repeat (2) @(posedge clk);
    #1 rst_i = 0;
  endtask

  task automatic clear_logs();
    wr_log_cyc.delete(); wr_log_addr.delete(); wr_log_data.delete();
    pop_log_data.delete(); pop_log_cyc.delete();
    busy_cnt = 0; req_cnt = 0;
  endtask

  task automatic start_xfer(input bit mode, input logic [AW-1:0] base, input int len, input bit fixed);
    wr_src_q.delete();
    if (mode) for (int i = 0; i < len; i++) wr_src_q.push_back(fixed ? 32'hA0 + i : $urandom);
    done_seen = 0;
    @(posedge clk); #1;
    start_i = 1; write_mode_i = mode; base_addr_i = base; len_i = LW'(len);
    @(posedge clk); #1;
    start_i = 0; write_mode_i = 1'($urandom_range(0, 1));
    base_addr_i = AW'($urandom_range(0, N - 1)); len_i = LW'($urandom_range(0, N));
  endtask

  task automatic wait_done(input int budget, input bit inject);
    int k = 0;
    while (!done_seen && (k < budget)) begin
      @(posedge clk); #1;
      if (inject && (k == 2)) begin
        start_i = 1; base_addr_i = AW'(N / 2); len_i = LW'(3); write_mode_i = ~write_mode_i;
      end else begin
        start_i = 0;
      end
      k++;
    end
    start_i = 0;
    if (!done_seen) begin
      chk("done_timeout", done_seen, 1);
      apply_reset();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  logic [AW-1:0] t1_addr [4];
  logic [31:0]   t2_data [3];
  bit            md;
  int            ln;

  initial begin
    rst_i = 1; start_i = 0; write_mode_i = 0; base_addr_i = '0; len_i = '0;
    in_valid_i = 0; in_data_i = '0; out_ready_i = 0; rdata_i = '0;
    vmode = 0; rmode = 0; rd_pend = 0; done_seen = 0;
    for (int i = 0; i < N; i++) begin
      sram[i]    = 32'(i) ^ 32'h55AA;
      ref_mem[i] = 32'(i) ^ 32'h55AA;
    end
    t1_addr = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    t2_data = '{32'h55BA, 32'h55BB, 32'h55B8};

    repeat (3) @(posedge clk);
    #1 rst_i = 0;
    @(posedge clk); #1;
    chk("reset_idle_state", dbg_state_o, 2'd0);

    // Wrapping write burst with valid held high.
    clear_logs(); vmode = 0; rmode = 0;
    start_xfer(1, 10'h3FE, 4, 1);
    wait_done(50, 0);
    chk("t1_nwr", wr_log_addr.size(), 4);
    if (wr_log_addr.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t1_addr", wr_log_addr[i], t1_addr[i]);
        chk("t1_data", wr_log_data[i], 32'hA0 + i);
      end
      chk("t1_first_lat", wr_log_cyc[0] - start_cyc, 1);
      chk("t1_span", wr_log_cyc[3] - wr_log_cyc[0], 3);
      chk("t1_done_lat", done_cyc - wr_log_cyc[3], 1);
    end

    // Short read burst, consumer always ready.
    clear_logs();
    start_xfer(0, 10'h010, 3, 0);
    wait_done(50, 0);
    chk("t2_npop", pop_log_data.size(), 3);
    if (pop_log_data.size() == 3) begin
      for (int i = 0; i < 3; i++) chk("t2_data", pop_log_data[i], t2_data[i]);
      chk("t2_span", pop_log_cyc[2] - pop_log_cyc[0], 2);
    end

    // Read under alternating backpressure.
    clear_logs(); rmode = 1;
    start_xfer(0, 10'h100, 8, 0);
    wait_done(100, 0);
    chk("t3_npop", pop_log_data.size(), 8);
    if (pop_log_data.size() == 8) chk("t3_first", pop_log_data[0], 32'h54AA);

    // Zero-length transfer.
    clear_logs(); rmode = 0;
    start_xfer(0, 10'h055, 0, 0);
    wait_done(20, 0);
    chk("t4_done_lat", done_cyc - start_cyc, 1);
    chk("t4_busy_cycles", busy_cnt, 1);
    chk("t4_reqs", req_cnt, 0);

    // Stray start during a write with gappy valid.
    clear_logs(); vmode = 1;
    start_xfer(1, 10'h200, 10, 0);
    wait_done(200, 1);
    chk("t5_nwr", wr_log_addr.size(), 10);
    if (wr_log_addr.size() == 10) begin
      chk("t5_first_addr", wr_log_addr[0], 10'h200);
      chk("t5_last_addr", wr_log_addr[9], 10'h209);
    end

    // Reset while stalled in DRAIN, then a clean transfer.
    clear_logs(); vmode = 0; rmode = 3;
    start_xfer(0, 10'h020, 2, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("t6_in_drain", dbg_state_o, 2'd2);
    chk("t6_busy", busy_o, 1);
    apply_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("t6_no_done", done_seen, 0);
    clear_logs(); rmode = 0;
    start_xfer(0, 10'h020, 2, 0);
    wait_done(50, 0);
    chk("t6_after_npop", pop_log_data.size(), 2);

    // Randomized transfers.
    for (int t = 0; t < 30; t++) begin
      md = 1'($urandom_range(0, 1));
      ln = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom_range(1, 24);
      vmode = $urandom_range(0, 1);
      rmode = $urandom_range(0, 2);
      start_xfer(md, AW'($urandom_range(0, N - 1)), ln, 0);
      wait_done(40 * ln + 40, (ln >= 6) && ($urandom_range(0, 1) == 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
